sha256_msg_ctrl: RTL and testbench
==================================

Name: sha256_msg_ctrl

Overview:
Message-level sequencer between the AHB packet constructor and the sha256_stream engine in the SHA-256 accelerator wrapper. It accepts one configuration per message (length in bits, scheme) and gates 512-bit blocks into the engine, pulsing init on the first block and next on each later block. It waits for each compression to finish, then captures the final digest and presents it to the packet deconstructor over a valid/ready handshake. It also keeps message/block counters and sticky error flags for the wrapper register block.

Parameters:
INPACKETWIDTH, 512, block width (fixed 512 for SHA-256)
OUTPACKETWIDTH, 256, digest width
CFGSIZEWIDTH, 64, message-length field width in bits; block counter width BCW = CFGSIZEWIDTH-8

Ports:
hclk  in  1  clock
hreset  in  1  synchronous active-high reset
cfg_size  in  CFGSIZEWIDTH  message length in bits
cfg_scheme  in  2  0=SHA-256, 1=SHA-224, 2/3 illegal
cfg_valid  in  1  config valid
cfg_ready  out  1  config ready
in_packet  in  INPACKETWIDTH  padded block from constructor
in_packet_last  in  1  final block of message
in_packet_valid  in  1  block valid
in_packet_ready  out  1  block ready
eng_block  out  INPACKETWIDTH  block held to engine
eng_mode  out  1  1=SHA-256, 0=SHA-224
eng_init  out  1  one-cycle start, first block
eng_next  out  1  one-cycle start, subsequent block
eng_ready  in  1  engine idle
eng_done  in  1  one-cycle compression-complete pulse
eng_digest  in  OUTPACKETWIDTH  engine digest, valid when eng_done=1
out_packet  out  OUTPACKETWIDTH  captured digest
out_packet_last  out  1  tied 1 whenever out_packet_valid=1
out_packet_valid  out  1  digest valid
out_packet_ready  in  1  digest accepted
msg_count  out  16  completed messages, wraps at 0xFFFF->0
block_count  out  BCW  blocks issued in current message
err_len  out  1  sticky: block count does not match cfg_size
err_cfg  out  1  sticky: illegal scheme
err_clear  in  1  clears both sticky flags

Behaviour:
- Reset (hreset=1 at a clock edge) clears all registers. Every output is 0 and the state is IDLE. Reset mid-message discards the message and any pending digest, with no engine pulse issued.
- Expected blocks: exp = (cfg_size + 576) >> 9, computed at CFGSIZEWIDTH+1 bits and latched at config accept. Examples: 0 gives 1, 447 gives 1, 448 gives 2, 512 gives 2.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready:
  - scheme 0/1: latch exp, set eng_mode, clear block_count, go to WAIT_BLK next cycle.
  - scheme 2/3: set err_cfg and stay in IDLE (config consumed).
- WAIT_BLK: in_packet_ready = eng_ready. On handshake at cycle M:
  - latch in_packet into eng_block, latch last, go to ISSUE.
  - eng_block stays stable until the next accepted block.
- ISSUE (one cycle, M+1): eng_init=1 if block_count==0, else eng_next=1. block_count increments. Go to BUSY.
- BUSY: in_packet_ready=0. On eng_done at cycle D:
  - If the latched last=1: capture eng_digest into out_packet and go to OUT. out_packet_valid=1 from D+1.
  - Else return to WAIT_BLK.
  - eng_done outside BUSY is ignored.
- err_len is set on block acceptance when either condition holds:
  - last=1 and block_count+1 != exp, or
  - last=0 and block_count+1 >= exp.
  The message always terminates only on in_packet_last.
- OUT: out_packet and out_packet_valid are held until out_packet_ready. On the handshake:
  - msg_count increments and out_packet_valid drops the next cycle.
  - Return to IDLE; cfg_ready=1 that same next cycle.
- Minimum latency is config accept to cfg_ready: 1 + per block (1 accept + 1 issue + engine time) + 1 output.
- err_clear clears the flags the following cycle. If a set and err_clear occur in the same cycle, set wins.
- eng_init and eng_next are never both 1 and are never high for more than one cycle.

Test Plan:
1. cfg_size=0 and scheme 0, then one block with last=1 and eng_done 64 cycles later -> single eng_init pulse, eng_mode=1, out_packet equals the digest one cycle after eng_done, msg_count=1, err_len=0.
2. cfg_size=512, two blocks (second with last=1) -> eng_init then eng_next, block_count=2, one digest output, err_len=0.
3. cfg_size=448 with a single block marked last -> err_len=1 and digest still delivered; err_clear pulse -> err_len=0 next cycle.
4. scheme=2 -> err_cfg=1, cfg_ready remains 1, no in_packet_ready and no engine pulses; scheme=1 follow-up -> eng_mode=0.
5. Hold out_packet_ready=0 for 10 cycles in OUT -> out_packet stable and valid, in_packet_ready=0 and cfg_ready=0; release -> IDLE next cycle.
6. Assert hreset during BUSY of a 3-block message -> all outputs 0 next cycle; a fresh message afterwards completes normally with msg_count=1.

Source files
------------

// File: rtl/sha256_msg_ctrl.sv
// Message-level sequencer: accepts one config per message, feeds 512-bit blocks to the
// SHA-256 engine with init/next pulses, then presents the final digest over valid/ready.
//
// state    | meaning
// IDLE     | waiting for a message configuration
// WAIT_BLK | waiting for the next padded block (and an idle engine)
// ISSUE    | one-cycle init/next pulse to the engine
// BUSY     | engine compressing, waiting for eng_done
// OUT      | digest held until the deconstructor accepts it
module sha256_msg_ctrl #(
  parameter int INPACKETWIDTH  = 512,
  parameter int OUTPACKETWIDTH = 256,
  parameter int CFGSIZEWIDTH   = 64,
  localparam int BCW           = CFGSIZEWIDTH - 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [CFGSIZEWIDTH-1:0]   cfg_size,
  input  logic [1:0]                cfg_scheme,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [INPACKETWIDTH-1:0]  in_packet,
  input  logic                      in_packet_last,
  input  logic                      in_packet_valid,
  output logic                      in_packet_ready,
  output logic [INPACKETWIDTH-1:0]  eng_block,
  output logic                      eng_mode,
  output logic                      eng_init,
  output logic                      eng_next,
  input  logic                      eng_ready,
  input  logic                      eng_done,
  input  logic [OUTPACKETWIDTH-1:0] eng_digest,
  output logic [OUTPACKETWIDTH-1:0] out_packet,
  output logic                      out_packet_last,
  output logic                      out_packet_valid,
  input  logic                      out_packet_ready,
  output logic [15:0]               msg_count,
  output logic [BCW-1:0]            block_count,
  output logic                      err_len,
  output logic                      err_cfg,
  input  logic                      err_clear
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BLK, S_ISSUE, S_BUSY, S_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [BCW-1:0]            exp_q, exp_d;
  logic                      mode_q, mode_d;
  logic [BCW-1:0]            bc_q, bc_d;
  logic [INPACKETWIDTH-1:0]  blk_q, blk_d;
  logic                      last_q, last_d;
  logic [OUTPACKETWIDTH-1:0] out_q, out_d;
  logic [15:0]               msg_q, msg_d;
  logic                      err_len_q, err_len_d;
  logic                      err_cfg_q, err_cfg_d;
  logic                      len_set, cfg_set;
  logic [BCW:0]              bc_inc;

  // Count after this block is issued, one bit wider so it never wraps against exp_q.
  assign bc_inc = {1'b0, bc_q} + {{BCW{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mode_d  = mode_q;
    bc_d    = bc_q;
    blk_d   = blk_q;
    last_d  = last_q;
    out_d   = out_q;
    msg_d   = msg_q;
    len_set = 1'b0;
    cfg_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_scheme[1]) begin
            cfg_set = 1'b1;
          end else begin
            // Blocks = ceil((len + 1 + 64) / 512) after padding.
            exp_d   = BCW'(({1'b0, cfg_size} + (CFGSIZEWIDTH+1)'(576)) >> 9);
            mode_d  = ~cfg_scheme[0];
            bc_d    = '0;
            state_d = S_WAIT_BLK;
          end
        end
      end
      S_WAIT_BLK: begin
        if (in_packet_valid && eng_ready) begin
          blk_d   = in_packet;
          last_d  = in_packet_last;
          len_set = in_packet_last ? (bc_inc != {1'b0, exp_q})
                                   : (bc_inc >= {1'b0, exp_q});
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bc_d    = bc_inc[BCW-1:0];
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (eng_done) begin
          if (last_q) begin
            out_d   = eng_digest;
            state_d = S_OUT;
          end else begin
            state_d = S_WAIT_BLK;
          end
        end
      end
      S_OUT: begin
        if (out_packet_ready) begin
          msg_d   = msg_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_len_d = len_set | (err_len_q & ~err_clear);
    err_cfg_d = cfg_set | (err_cfg_q & ~err_clear);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= S_IDLE;
      exp_q     <= '0;
      mode_q    <= 1'b0;
      bc_q      <= '0;
      blk_q     <= '0;
      last_q    <= 1'b0;
      out_q     <= '0;
      msg_q     <= '0;
      err_len_q <= 1'b0;
      err_cfg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      mode_q    <= mode_d;
      bc_q      <= bc_d;
      blk_q     <= blk_d;
      last_q    <= last_d;
      out_q     <= out_d;
      msg_q     <= msg_d;
      err_len_q <= err_len_d;
      err_cfg_q <= err_cfg_d;
    end
  end

  // Ready is masked while reset is held so every output reads 0 during reset.
  assign cfg_ready        = (state_q == S_IDLE) && !hreset;
  assign in_packet_ready  = (state_q == S_WAIT_BLK) && eng_ready;
  assign eng_init         = (state_q == S_ISSUE) && (bc_q == '0);
  assign eng_next         = (state_q == S_ISSUE) && (bc_q != '0);
  assign eng_block        = blk_q;
  assign eng_mode         = mode_q;
  assign out_packet       = out_q;
  assign out_packet_valid = (state_q == S_OUT);
  assign out_packet_last  = (state_q == S_OUT);
  assign msg_count        = msg_q;
  assign block_count      = bc_q;
  assign err_len          = err_len_q;
  assign err_cfg          = err_cfg_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Self-checking bench for sha256_msg_ctrl: table of messages driven through a
// cycle-exact engine model, digests tracked in a scoreboard queue.
module tb_sha256_msg_ctrl;

  localparam int BCW = 56;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [63:0]  cfg_size;
  logic [1:0]   cfg_scheme;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [511:0] in_packet;
  logic         in_packet_last;
  logic         in_packet_valid;
  logic         in_packet_ready;
  logic [511:0] eng_block;
  logic         eng_mode;
  logic         eng_init;
  logic         eng_next;
  logic         eng_ready;
  logic         eng_done;
  logic [255:0] eng_digest;
  logic [255:0] out_packet;
  logic         out_packet_last;
  logic         out_packet_valid;
  logic         out_packet_ready;
  logic [15:0]  msg_count;
  logic [BCW-1:0] block_count;
  logic         err_len;
  logic         err_cfg;
  logic         err_clear;

  sha256_msg_ctrl dut (
    .hclk(hclk), .hreset(hreset),
    .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .in_packet(in_packet), .in_packet_last(in_packet_last),
    .in_packet_valid(in_packet_valid), .in_packet_ready(in_packet_ready),
    .eng_block(eng_block), .eng_mode(eng_mode), .eng_init(eng_init), .eng_next(eng_next),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_digest(eng_digest),
    .out_packet(out_packet), .out_packet_last(out_packet_last),
    .out_packet_valid(out_packet_valid), .out_packet_ready(out_packet_ready),
    .msg_count(msg_count), .block_count(block_count),
    .err_len(err_len), .err_cfg(err_cfg), .err_clear(err_clear)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [63:0] size;
    logic [1:0]  scheme;
    int          nblk;
    int          lat;
    int          hold;
    bit          stall;
    bit          exp_err;
    bit          exp_mode;
  } msg_vec_t;

  msg_vec_t     vecs[7];
  logic [255:0] sb_q[$];
  int           checks = 0;
  int           failures = 0;
  int           exp_msg = 0;
  logic         pulse_prev = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Engine start pulses: never both at once and never two cycles in a row.
  always @(negedge hclk) begin
    if (!hreset && (eng_init || eng_next || pulse_prev)) begin
      checks++;
      if ((eng_init && eng_next) || ((eng_init || eng_next) && pulse_prev)) begin
        failures++;
        $display("FAIL eng_pulse actual init=%0b next=%0b prev=%0b expected single one-cycle pulse",
                 eng_init, eng_next, pulse_prev);
      end
    end
    pulse_prev = eng_init || eng_next;
  end

  task automatic clear_errs;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    check("err_len_cleared", err_len, 0);
    check("err_cfg_cleared", err_cfg, 0);
  endtask

  task automatic run_msg(input msg_vec_t v);
    logic [511:0] pkt;
    logic [255:0] dg;
    cfg_size   = v.size;
    cfg_scheme = v.scheme;
    cfg_valid  = 1'b1;
    #1;
    check("cfg_ready_idle", cfg_ready, 1);
    tick;
    cfg_valid = 1'b0;
    check("eng_mode", eng_mode, v.exp_mode);
    check("cfg_ready_busy", cfg_ready, 0);
    for (int i = 0; i < v.nblk; i++) begin
      pkt             = rand512();
      in_packet       = pkt;
      in_packet_last  = (i == v.nblk - 1);
      in_packet_valid = 1'b1;
      if (v.stall) begin
        eng_ready = 1'b0;
        #1;
        check("in_ready_stall", in_packet_ready, 0);
        tick;
      end
      eng_ready = 1'b1;
      #1;
      check("in_ready_wait", in_packet_ready, 1);
      tick;
      in_packet_valid = 1'b0;
      in_packet       = rand512();
      eng_ready       = 1'b0;
      check("eng_init", eng_init, (i == 0));
      check("eng_next", eng_next, (i != 0));
      check("eng_block", eng_block, pkt);
      tick;
      check("pulse_gone", eng_init | eng_next, 0);
      check("block_count", block_count, i + 1);
      eng_ready = 1'b1;
      in_packet_valid = 1'b1;
      #1;
      check("in_ready_busy", in_packet_ready, 0);
      in_packet_valid = 1'b0;
      eng_ready = 1'b0;
      repeat (v.lat - 1) tick;
      dg         = rand256();
      eng_done   = 1'b1;
      eng_digest = dg;
      if (i == v.nblk - 1) sb_q.push_back(dg);
      tick;
      eng_done   = 1'b0;
      eng_digest = rand256();
      check("eng_block_stable", eng_block, pkt);
    end
    in_packet_valid = 1'b1;
    eng_ready       = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      check("hold_valid", out_packet_valid, 1);
      check("hold_in_ready", in_packet_ready, 0);
      check("hold_cfg_ready", cfg_ready, 0);
      if (sb_q.size() > 0) check("hold_digest", out_packet, sb_q[0]);
      tick;
    end
    in_packet_valid = 1'b0;
    eng_ready       = 1'b0;
    check("out_valid", out_packet_valid, 1);
    check("out_last", out_packet_last, 1);
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard actual=empty expected=pending digest");
    end else begin
      dg = sb_q.pop_front();
      checks--;
      check("out_digest", out_packet, dg);
    end
    out_packet_ready = 1'b1;
    tick;
    out_packet_ready = 1'b0;
    exp_msg++;
    check("out_valid_drop", out_packet_valid, 0);
    check("cfg_ready_back", cfg_ready, 1);
    check("msg_count", msg_count, exp_msg);
    check("final_block_count", block_count, v.nblk);
    check("err_len", err_len, v.exp_err);
  endtask

  initial begin
    //          size     scheme nblk lat hold stall err mode
    vecs[0] = '{64'd0,    2'd0, 1, 64, 0,  0, 0, 1};
    vecs[1] = '{64'd512,  2'd0, 2, 5,  0,  1, 0, 1};
    vecs[2] = '{64'd448,  2'd0, 1, 3,  0,  0, 1, 1};
    vecs[3] = '{64'd447,  2'd1, 1, 2,  0,  0, 0, 0};
    vecs[4] = '{64'd1000, 2'd0, 3, 4,  10, 0, 0, 1};
    vecs[5] = '{64'd100,  2'd0, 2, 2,  0,  0, 1, 1};
    vecs[6] = '{64'd960,  2'd1, 2, 1,  0,  0, 1, 0};

    hreset = 1'b1; cfg_size = '0; cfg_scheme = '0; cfg_valid = 1'b0;
    in_packet = '0; in_packet_last = 1'b0; in_packet_valid = 1'b0;
    eng_ready = 1'b0; eng_done = 1'b0; eng_digest = '0;
    out_packet_ready = 1'b0; err_clear = 1'b0;
    repeat (3) tick;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_out_valid", out_packet_valid, 0);
    check("rst_msg_count", msg_count, 0);
    check("rst_eng_mode", eng_mode, 0);
    hreset = 1'b0;
    #1;
    check("idle_cfg_ready", cfg_ready, 1);

    foreach (vecs[n]) begin
      clear_errs();
      run_msg(vecs[n]);
    end

    // Illegal scheme consumed in IDLE; a simultaneous err_clear loses to the set.
    clear_errs();
    cfg_size = 64'd0; cfg_scheme = 2'd2; cfg_valid = 1'b1; err_clear = 1'b1;
    in_packet_valid = 1'b1; eng_ready = 1'b1;
    tick;
    cfg_valid = 1'b0; err_clear = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("illegal_err_cfg", err_cfg, 1);
      check("illegal_cfg_ready", cfg_ready, 1);
      check("illegal_in_ready", in_packet_ready, 0);
      check("illegal_pulses", eng_init | eng_next, 0);
      tick;
    end
    in_packet_valid = 1'b0; eng_ready = 1'b0;
    cfg_scheme = 2'd3; cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
    check("illegal3_cfg_ready", cfg_ready, 1);
    clear_errs();
    run_msg(vecs[3]);

    // Reset while the engine is compressing the first of three blocks.
    cfg_size = 64'd1000; cfg_scheme = 2'd0; cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
    in_packet = rand512(); in_packet_last = 1'b0; in_packet_valid = 1'b1; eng_ready = 1'b1;
    tick;
    in_packet_valid = 1'b0; eng_ready = 1'b0;
    tick;
    check("pre_rst_block_count", block_count, 1);
    hreset = 1'b1;
    tick;
    check("mid_rst_cfg_ready", cfg_ready, 0);
    check("mid_rst_in_ready", in_packet_ready, 0);
    check("mid_rst_eng_block", eng_block, 0);
    check("mid_rst_eng_mode", eng_mode, 0);
    check("mid_rst_pulses", eng_init | eng_next, 0);
    check("mid_rst_out", out_packet, 0);
    check("mid_rst_out_valid", out_packet_valid | out_packet_last, 0);
    check("mid_rst_msg_count", msg_count, 0);
    check("mid_rst_block_count", block_count, 0);
    check("mid_rst_errs", {err_len, err_cfg}, 0);
    hreset = 1'b0;
    eng_done = 1'b1; eng_digest = rand256();
    tick;
    eng_done = 1'b0;
    check("post_rst_done_ignored", out_packet_valid, 0);
    check("post_rst_cfg_ready", cfg_ready, 1);
    exp_msg = 0;
    run_msg(vecs[1]);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
